// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared branch predictor types and counter encodings
package rv32i_pkg;

   localparam int BP_XLEN = 32;

   typedef logic [1:0] bp_ctr_t;

   localparam bp_ctr_t BP_SNT = 2'b00;
   localparam bp_ctr_t BP_WNT = 2'b01;
   localparam bp_ctr_t BP_WT  = 2'b10;
   localparam bp_ctr_t BP_ST  = 2'b11;

   // Tag and target are held at full XLEN; narrower PCs are zero-extended.
   typedef struct packed {
      logic               valid;
      logic [BP_XLEN-1:0] tag;
      bp_ctr_t            ctr;
      logic [BP_XLEN-1:0] target;
   } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational 2-bit saturating up/down counter step
module bp_sat_counter
   import rv32i_pkg::*;
(
   input  bp_ctr_t ctr_in,
   input  logic    taken,
   output bp_ctr_t ctr_out
);

   always_comb begin
      ctr_out = ctr_in;
      if (taken) begin
         if (ctr_in != BP_ST) ctr_out = ctr_in + 2'd1;
      end else begin
         if (ctr_in != BP_SNT) ctr_out = ctr_in - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BHT+BTB with same-cycle lookup,
// execute-stage training, registered mispredict flag and statistics
module branch_predictor
   import rv32i_pkg::*;
#(
   parameter  int DataWidth  = 32,
   parameter  int Entries    = 16,
   localparam int IndexWidth = $clog2(Entries)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DataWidth-1:0] lookup_pc,
   output logic                 predict_taken,
   output logic [DataWidth-1:0] predict_target,
   input  logic                 update_en,
   input  logic [DataWidth-1:0] update_pc,
   input  logic                 update_taken,
   input  logic [DataWidth-1:0] update_target,
   input  logic                 flush_table,
   output logic                 mispredict,
   output logic [31:0]          branch_count,
   output logic [31:0]          mispredict_count
);

   localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, ctr: BP_WNT, target: '0};

   bp_entry_t table_q [Entries];
   bp_entry_t table_d [Entries];
   logic        mispredict_q, mispredict_d;
   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] mispredict_count_q, mispredict_count_d;

   logic [IndexWidth-1:0] lk_idx, up_idx;
   logic [BP_XLEN-1:0]    lk_tag, up_tag;
   bp_entry_t             lk_entry, up_entry;
   logic                  lk_hit, up_hit, up_dir, mis_cond;
   bp_ctr_t               up_ctr_next;

   bp_sat_counter u_sat (
      .ctr_in  (up_entry.ctr),
      .taken   (update_taken),
      .ctr_out (up_ctr_next)
   );

   always_comb begin
      lk_idx   = lookup_pc[IndexWidth+1:2];
      lk_tag   = BP_XLEN'(lookup_pc >> (IndexWidth + 2));
      lk_entry = table_q[lk_idx];
      lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
      predict_taken  = lk_hit && lk_entry.ctr[1];
      predict_target = predict_taken ? lk_entry.target[DataWidth-1:0]
                                     : lookup_pc + DataWidth'(4);
   end

   always_comb begin
      up_idx   = update_pc[IndexWidth+1:2];
      up_tag   = BP_XLEN'(update_pc >> (IndexWidth + 2));
      up_entry = table_q[up_idx];
      up_hit   = up_entry.valid && (up_entry.tag == up_tag);
      up_dir   = up_hit && up_entry.ctr[1];
      mis_cond = update_en &&
                 ((up_dir != update_taken) ||
                  (up_dir && update_taken && (up_entry.target != BP_XLEN'(update_target))));

      mispredict_d       = mis_cond;
      branch_count_d     = branch_count_q + {31'd0, update_en};
      mispredict_count_d = mispredict_count_q + {31'd0, mis_cond};

      // Flush wins over training; statistics above still use pre-flush state.
      table_d = table_q;
      if (flush_table) begin
         for (int i = 0; i < Entries; i++) table_d[i].valid = 1'b0;
      end else if (update_en) begin
         if (up_hit) begin
            table_d[up_idx].ctr = up_ctr_next;
            if (update_taken) table_d[up_idx].target = BP_XLEN'(update_target);
         end else if (update_taken) begin
            table_d[up_idx] = '{valid: 1'b1, tag: up_tag, ctr: BP_WT,
                                target: BP_XLEN'(update_target)};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Entries; i++) table_q[i] <= ENTRY_RST;
         mispredict_q       <= 1'b0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         for (int i = 0; i < Entries; i++) table_q[i] <= table_d[i];
         mispredict_q       <= mispredict_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign mispredict       = mispredict_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule
